mmcm_drp_sequencer: RTL and testbench

Parametrised reconfiguration engine for the Xilinx-7 MMCM wrappers. It takes a loadable table of up to `NUM_REGS` DRP register updates and applies them to the MMCM. Each update is a masked read-modify-write performed while the MMCM is held in reset. After the table is applied, it releases reset, waits for `LOCKED` with a timeout and reports status. It drives the packed 64-bit `reconfig_to_pll` bus consumed by `pll_*` wrappers and reads back `reconfig_from_pll`, replacing the host-side bit-banging of DRP.

---
 rtl/mmcm_drp_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_mmcm_drp_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmcm_drp_sequencer.sv
// DRP reconfiguration engine for 7-series MMCM wrappers.
// Applies a table of masked read-modify-write updates with the MMCM held in reset, then waits for lock.
module mmcm_drp_sequencer #(
  parameter int unsigned NUM_REGS     = 16,
  parameter int unsigned RST_HOLD     = 8,
  parameter int unsigned DRDY_TIMEOUT = 255,
  parameter int unsigned LOCK_TIMEOUT = 1_000_000,
  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int unsigned CNT_W = $clog2(NUM_REGS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tbl_we,
  input  logic [IDX_W-1:0] tbl_idx,
  input  logic [6:0]       tbl_addr,
  input  logic [15:0]      tbl_keep,
  input  logic [15:0]      tbl_data,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [63:0]      reconfig_to_pll,
  input  logic [63:0]      reconfig_from_pll
);

  localparam int unsigned TMR_A   = (RST_HOLD > DRDY_TIMEOUT) ? RST_HOLD : DRDY_TIMEOUT;
  localparam int unsigned TMR_MAX = (TMR_A > LOCK_TIMEOUT) ? TMR_A : LOCK_TIMEOUT;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_HOLD      = 4'd1;
  localparam logic [3:0] S_RD        = 4'd2;
  localparam logic [3:0] S_RD_WAIT   = 4'd3;
  localparam logic [3:0] S_WR        = 4'd4;
  localparam logic [3:0] S_WR_WAIT   = 4'd5;
  localparam logic [3:0] S_RELEASE   = 4'd6;
  localparam logic [3:0] S_LOCK_WAIT = 4'd7;
  localparam logic [3:0] S_FINISH    = 4'd8;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] keep;
    logic [15:0] data;
  } tbl_entry_t;

  tbl_entry_t tbl [NUM_REGS];

  logic [3:0]       state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             den_q, den_d, dwe_q, dwe_d, rst_mmcm_q, rst_mmcm_d;
  logic [15:0]      din_q, din_d;
  logic [6:0]       daddr_q, daddr_d;
  logic [CNT_W-1:0] idx_q, idx_d, cnt_q, cnt_d, idx_inc, count_sat;
  logic [TMR_W-1:0] timer_q, timer_d;
  tbl_entry_t       cur, nxt;

  logic [15:0] dout;
  logic        drdy, locked, unused_from_pll;

  assign dout            = reconfig_from_pll[15:0];
  assign drdy            = reconfig_from_pll[16];
  assign locked          = reconfig_from_pll[17];
  assign unused_from_pll = &{1'b0, reconfig_from_pll[63:18]};

  assign idx_inc   = idx_q + CNT_W'(1);
  assign count_sat = (count > CNT_W'(NUM_REGS)) ? CNT_W'(NUM_REGS) : count;
  assign cur       = tbl[idx_q[IDX_W-1:0]];
  assign nxt       = tbl[idx_inc[IDX_W-1:0]];

  // Table has no reset so a host-loaded configuration survives rst_n.
  always_ff @(posedge clk) begin
    if (tbl_we && !busy_q && (32'(tbl_idx) < NUM_REGS)) begin
      tbl[tbl_idx] <= '{addr: tbl_addr, keep: tbl_keep, data: tbl_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= 2'd0;
      den_q      <= 1'b0;
      dwe_q      <= 1'b0;
      rst_mmcm_q <= 1'b0;
      din_q      <= 16'd0;
      daddr_q    <= 7'd0;
      idx_q      <= '0;
      cnt_q      <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      den_q      <= den_d;
      dwe_q      <= dwe_d;
      rst_mmcm_q <= rst_mmcm_d;
      din_q      <= din_d;
      daddr_q    <= daddr_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
    end
  end

  // Next state plus next values of every registered output, aligned to state_d.
  always_comb begin
    state_d    = state_q;
    error_d    = error_q;
    err_code_d = err_code_q;
    din_d      = din_q;
    daddr_d    = daddr_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d      = count_sat;
          error_d    = 1'b0;
          err_code_d = 2'd0;
          idx_d      = '0;
          timer_d    = '0;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (timer_q == TMR_W'(RST_HOLD - 1)) begin
          timer_d = '0;
          if (cnt_q != '0) begin
            daddr_d = cur.addr;
            state_d = S_RD;
          end else begin
            state_d = S_RELEASE;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_RD: begin
        timer_d = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (drdy) begin
          din_d   = (dout & cur.keep) | (cur.data & ~cur.keep);
          state_d = S_WR;
        end else if (timer_q == TMR_W'(DRDY_TIMEOUT - 1)) begin
          error_d    = 1'b1;
          err_code_d = 2'd1;
          state_d    = S_RELEASE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_WR: begin
        timer_d = '0;
        state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (drdy) begin
          if (idx_inc < cnt_q) begin
            idx_d   = idx_inc;
            daddr_d = nxt.addr;
            state_d = S_RD;
          end else begin
            state_d = S_RELEASE;
          end
        end else if (timer_q == TMR_W'(DRDY_TIMEOUT - 1)) begin
          error_d    = 1'b1;
          err_code_d = 2'd1;
          state_d    = S_RELEASE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_RELEASE: begin
        timer_d = '0;
        state_d = S_LOCK_WAIT;
      end
      S_LOCK_WAIT: begin
        if (locked) begin
          state_d = S_FINISH;
        end else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
          error_d = 1'b1;
          if (err_code_q == 2'd0) err_code_d = 2'd2;
          state_d = S_FINISH;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    den_d      = (state_d == S_RD) || (state_d == S_WR);
    dwe_d      = (state_d == S_WR);
    rst_mmcm_d = (state_d == S_HOLD) || (state_d == S_RD) || (state_d == S_RD_WAIT) ||
                 (state_d == S_WR) || (state_d == S_WR_WAIT);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FINISH);
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign err_code = err_code_q;

  assign reconfig_to_pll = {37'd0, clk, rst_mmcm_q, dwe_q, den_q, daddr_q, din_q};

endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// Bench for mmcm_drp_sequencer: DRP/MMCM behavioural model plus a table-driven expectation model.
module tb_mmcm_drp_sequencer;

  localparam int unsigned NR = 8;
  localparam int unsigned RH = 8;
  localparam int unsigned DT = 20;
  localparam int unsigned LT = 100;
  localparam int unsigned IW = 3;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n, tbl_we, start;
  logic [IW-1:0] tbl_idx;
  logic [6:0]    tbl_addr;
  logic [15:0]   tbl_keep, tbl_data;
  logic [CW-1:0] count;
  logic          busy, done, error;
  logic [1:0]    err_code;
  logic [63:0]   to_pll, from_pll;

  logic [15:0] dout_m = 16'd0;
  logic        drdy_m = 1'b0, locked_m = 1'b0;
  logic        den, dwe, rst_mmcm;
  logic [6:0]  daddr;
  logic [15:0] din;

  assign from_pll = {46'd0, locked_m, drdy_m, dout_m};
  assign din      = to_pll[15:0];
  assign daddr    = to_pll[22:16];
  assign den      = to_pll[23];
  assign dwe      = to_pll[24];
  assign rst_mmcm = to_pll[25];

  always #5 clk = ~clk;

  mmcm_drp_sequencer #(.NUM_REGS(NR), .RST_HOLD(RH), .DRDY_TIMEOUT(DT), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst_n(rst_n), .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_addr(tbl_addr),
    .tbl_keep(tbl_keep), .tbl_data(tbl_data), .start(start), .count(count), .busy(busy),
    .done(done), .error(error), .err_code(err_code), .reconfig_to_pll(to_pll),
    .reconfig_from_pll(from_pll)
  );

  typedef struct packed {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] data;
  } acc_t;

  int total = 0, bad = 0, cyc = 0;
  int lat = 1, drop_read = 0, lock_n = 20, read_no = 0, pend = 0, lcnt = 0, viol = 0;
  int rst_hi = 0, busy_hi = 0;
  logic [15:0] mem [128];
  logic [6:0]  sh_addr [NR];
  logic [15:0] sh_keep [NR];
  logic [15:0] sh_data [NR];
  acc_t        acc_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // DRP slave: drdy comes lat cycles after den; one chosen read is never answered. MMCM locks lock_n cycles after release.
  always @(negedge clk) begin
    drdy_m = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) drdy_m = 1'b1;
    end
    if (den) begin
      if (pend > 0) viol++;
      acc_q.push_back(acc_t'({dwe, daddr, din}));
      if (dwe) begin
        mem[daddr] = din;
        pend = lat;
      end else begin
        read_no++;
        dout_m = mem[daddr];
        if (read_no != drop_read) pend = lat;
      end
    end
    if (rst_mmcm) begin
      lcnt = 0;
      locked_m = 1'b0;
    end else begin
      lcnt++;
      locked_m = (lock_n > 0) && (lcnt >= lock_n);
    end
    if (rst_mmcm) rst_hi++;
    if (busy) busy_hi++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic load(input int i, input logic [6:0] a, input logic [15:0] k, input logic [15:0] d);
    tbl_we = 1'b1; tbl_idx = IW'(i); tbl_addr = a; tbl_keep = k; tbl_data = d;
    tick();
    tbl_we = 1'b0;
    sh_addr[i] = a; sh_keep[i] = k; sh_data[i] = d;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "/drp_bits"}, 32'(to_pll[25:0]), 32'd0);
    chk({tag, "/status"}, {27'd0, busy, done, error, err_code}, 32'd0);
  endtask

  // n entries requested, l = drdy latency, dr = read number left unanswered (0 none), ln <= 0 means never lock.
  task automatic run(input string tag, input int n, input int l, input int dr, input int ln,
                     input bit poke, input bit b2b);
    int m, full, exp_err, exp_rst, dur, t0, d;
    bit got;
    logic [15:0] em [128];
    logic [15:0] nv;
    acc_t exq [$];
    m = (n > int'(NR)) ? int'(NR) : n;
    em = mem;
    full = 0;
    exp_err = 0;
    for (int e = 0; e < m; e++) begin
      exq.push_back(acc_t'({1'b0, sh_addr[e], 16'h0}));
      if (dr == e + 1) begin
        exp_err = 1;
        break;
      end
      nv = (em[sh_addr[e]] & sh_keep[e]) | (sh_data[e] & ~sh_keep[e]);
      em[sh_addr[e]] = nv;
      exq.push_back(acc_t'({1'b1, sh_addr[e], nv}));
      full++;
    end
    // Each access occupies den cycle plus l wait cycles; a lost drdy costs one read cycle plus the full timeout.
    exp_rst = RH + full * (2 + 2 * l) + ((exp_err == 1) ? 1 + int'(DT) : 0);
    if (exp_err == 0 && ln <= 0) exp_err = 2;
    dur = 1 + exp_rst + 1 + ((ln <= 0) ? int'(LT) : ln - 1);

    lat = l; drop_read = dr; lock_n = ln;
    acc_q.delete(); read_no = 0; viol = 0;
    start = 1'b1; count = CW'(n); t0 = cyc; rst_hi = 0; busy_hi = 0;
    tick();
    start = 1'b0;
    chk({tag, "/busy_rise"}, 32'(busy), 32'd1);
    chk({tag, "/err_clear"}, {29'd0, error, err_code}, 32'd0);
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (poke && i == 1) begin
        start = 1'b1; count = CW'(1);
        tbl_we = 1'b1; tbl_idx = IW'(0); tbl_addr = 7'h55;
        tbl_keep = 16'($urandom); tbl_data = 16'($urandom);
      end else begin
        start = 1'b0; tbl_we = 1'b0;
      end
      if (done) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    d = cyc;
    chk({tag, "/done_seen"}, 32'(got), 32'd1);
    chk({tag, "/err_code"}, 32'(err_code), 32'(exp_err));
    chk({tag, "/error"}, 32'(error), 32'(exp_err != 0));
    if (exp_err != 0) chk_rng({tag, "/duration"}, d - t0, dur - 1, dur + 1);
    else              chk({tag, "/duration"}, 32'(d - t0), 32'(dur));
    if (b2b) begin
      start = 1'b1; count = CW'(1);
    end
    tick();
    chk({tag, "/done_pulse"}, {30'd0, done, busy}, 32'd0);
    chk({tag, "/busy_cycles"}, 32'(busy_hi), 32'(d - t0));
    if (exp_err == 1) chk_rng({tag, "/rst_cycles"}, rst_hi, exp_rst - 1, exp_rst + 1);
    else              chk({tag, "/rst_cycles"}, 32'(rst_hi), 32'(exp_rst));
    chk({tag, "/acc_count"}, 32'(acc_q.size()), 32'(exq.size()));
    for (int i = 0; i < exq.size() && i < acc_q.size(); i++) begin
      if (exq[i].we) chk($sformatf("%s/acc%0d", tag, i), 32'(acc_q[i]), 32'(exq[i]));
      else chk($sformatf("%s/acc%0d", tag, i), 32'({acc_q[i].we, acc_q[i].addr}),
               32'({exq[i].we, exq[i].addr}));
    end
    chk({tag, "/overlap"}, 32'(viol), 32'd0);
    if (b2b) begin
      tick();
      start = 1'b0;
      chk({tag, "/b2b_accept"}, 32'(busy), 32'd1);
      got = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if (done) begin
          got = 1'b1;
          break;
        end
        tick();
      end
      chk({tag, "/b2b_done"}, {29'd0, got, err_code}, 32'd4);
      tick();
    end
  endtask

  initial begin
    bit got;
    rst_n = 1'b0; tbl_we = 1'b0; start = 1'b0; tbl_idx = '0; tbl_addr = '0;
    tbl_keep = '0; tbl_data = '0; count = '0;
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    tick(); tick();
    chk_idle("reset");
    rst_n = 1'b1;
    tick();
    chk_idle("post_reset");
    chk("dclk_high", 32'(to_pll[26]), 32'd1);
    chk("upper_zero", 32'(|to_pll[63:27]), 32'd0);
    @(negedge clk); #1;
    chk("dclk_low", 32'(to_pll[26]), 32'd0);
    tick();

    load(0, 7'h08, 16'h1000, 16'h0145);
    for (int i = 1; i < int'(NR); i++) load(i, 7'($urandom), 16'($urandom), 16'($urandom));
    mem[8] = 16'hFFFF;
    run("single", 1, 1, 0, 20, 1'b0, 1'b0);
    chk("single/wdata", 32'(acc_q[1].data), 32'h1145);

    run("three", 3, 1, 0, 15, 1'b1, 1'b0);
    run("drdy_to", 3, 1, 2, 10, 1'b0, 1'b0);
    repeat (5) tick();
    chk("sticky_err", {29'd0, error, err_code}, 32'd5);
    run("lock_to", 2, 1, 0, 0, 1'b0, 1'b0);
    run("zero", 0, 1, 0, 12, 1'b0, 1'b0);
    run("saturate", 12, 2, 0, 8, 1'b0, 1'b1);

    for (int it = 0; it < 6; it++) begin
      load($urandom_range(1, NR - 1), 7'($urandom), 16'($urandom), 16'($urandom));
      run($sformatf("rand%0d", it), $urandom_range(0, NR + 2), $urandom_range(1, 3), 0,
          $urandom_range(2, 30), 1'b0, 1'b0);
    end

    // Abort a sequence during the first write wait; the next run proves the table is intact.
    lat = 1; drop_read = 0; lock_n = 10;
    start = 1'b1; count = CW'(3);
    tick();
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (den && dwe) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("midrst/wr_seen", 32'(got), 32'd1);
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst/outputs", {28'd0, rst_mmcm, busy, den, done}, 32'd0);
    rst_n = 1'b1;
    tick(); tick();
    run("after_rst", 2, 1, 0, 6, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
